// File: rtl/sd_block_arbiter.sv
// sd_block_arbiter: two-client round-robin sequencer in front of a single SD
// card controller. It grants one client, fires a one-cycle execute with that
// client's op/address, steers the byte stream, and reports done/err per block.
//
// Handshake contract (client side): a client raises reqN and holds it until it
// sees doneN or errN. The grant is one-hot or zero. bstbN pulses for one cycle
// each time a byte moves for the granted client, in the same cycle that rbyte
// shows the byte. wbyteN must be valid for the whole time gntN is high.
// Withdrawing a request mid-transfer has no effect; the block runs to completion.
module sd_block_arbiter #(
    parameter int BLOCK_BYTES   = 512,
    parameter int START_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        btn_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        op0,
    input  logic        op1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [7:0]  wbyte0,
    input  logic [7:0]  wbyte1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [7:0]  rbyte,
    output logic        bstb0,
    output logic        bstb1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic        sdc_execute,
    output logic        sdc_op_code,
    output logic [31:0] sdc_block_address,
    output logic [7:0]  sdc_outgoing_byte,
    input  logic [7:0]  sdc_incoming_byte,
    input  logic        sdc_finished_byte,
    input  logic        sdc_finished_block,
    input  logic        sdc_busy,
    output logic [1:0]  dbg_state
);

    localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [9:0]    BLK      = 10'(BLOCK_BYTES);
    localparam logic [9:0]    CNT_MAX  = 10'h3FF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_START = 2'd2,
        S_XFER  = 2'd3
    } state_t;

    state_t        state_q;
    logic          sel_q;       // client currently served (0/1)
    logic          ptr_q;       // client favoured when both request
    logic [9:0]    byte_cnt_q;
    logic [9:0]    byte_cnt_d;
    logic [TW-1:0] tmo_q;
    logic          pick_d;

    // Client selection and saturating byte count including this cycle's byte
    always_comb begin
        pick_d     = req1 & (~req0 | ptr_q);
        byte_cnt_d = byte_cnt_q;
        if (sdc_finished_byte && (byte_cnt_q != CNT_MAX)) begin
            byte_cnt_d = byte_cnt_q + 10'd1;
        end
    end

    assign sdc_outgoing_byte = gnt0 ? wbyte0 : (gnt1 ? wbyte1 : 8'h00);
    assign dbg_state         = state_q;

    // Sequencer FSM with all client/controller outputs registered
    always_ff @(posedge clk or negedge btn_n) begin
        if (!btn_n) begin
            state_q           <= S_IDLE;
            sel_q             <= 1'b0;
            ptr_q             <= 1'b0;
            byte_cnt_q        <= '0;
            tmo_q             <= '0;
            gnt0              <= 1'b0;
            gnt1              <= 1'b0;
            rbyte             <= 8'h00;
            bstb0             <= 1'b0;
            bstb1             <= 1'b0;
            done0             <= 1'b0;
            done1             <= 1'b0;
            err0              <= 1'b0;
            err1              <= 1'b0;
            sdc_execute       <= 1'b0;
            sdc_op_code       <= 1'b0;
            sdc_block_address <= '0;
        end else begin
            sdc_execute <= 1'b0;
            bstb0       <= 1'b0;
            bstb1       <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // busy high also covers controller init after reset
                    if (!sdc_busy && (req0 || req1)) begin
                        sel_q             <= pick_d;
                        gnt0              <= ~pick_d;
                        gnt1              <= pick_d;
                        sdc_op_code       <= pick_d ? op1 : op0;
                        sdc_block_address <= pick_d ? addr1 : addr0;
                        state_q           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    sdc_execute <= 1'b1;
                    byte_cnt_q  <= '0;
                    tmo_q       <= '0;
                    state_q     <= S_START;
                end
                S_START: begin
                    if (sdc_busy) begin
                        state_q <= S_XFER;
                    end else if (tmo_q == TMO_LAST) begin
                        err0    <= ~sel_q;
                        err1    <= sel_q;
                        gnt0    <= 1'b0;
                        gnt1    <= 1'b0;
                        ptr_q   <= ~sel_q;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_XFER: begin
                    if (sdc_finished_byte) begin
                        rbyte      <= sdc_incoming_byte;
                        bstb0      <= ~sel_q;
                        bstb1      <= sel_q;
                        byte_cnt_q <= byte_cnt_d;
                    end
                    if (sdc_finished_block) begin
                        if (byte_cnt_d == BLK) begin
                            done0 <= ~sel_q;
                            done1 <= sel_q;
                        end else begin
                            err0 <= ~sel_q;
                            err1 <= sel_q;
                        end
                        gnt0    <= 1'b0;
                        gnt1    <= 1'b0;
                        ptr_q   <= ~sel_q;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
